lcd_hex_driver: RTL and testbench

- Downstream display stage of the MIPS system. It consumes the two 32-bit words and the 4-bit label selector that the output selector produces, and drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel bus.
- Runs the power-up init sequence, then repeatedly writes frames: line 1 = 8-char label + 8 hex digits of data1; line 2 = 8 spaces + 8 hex digits of data2.
- Replaces the existing LCD test driver in the system top level.

---
 rtl/lcd_hex_pkg.sv | 86 ++++++++
 rtl/lcd_hex_driver_write_cycle.sv | 79 +++++++
 rtl/lcd_hex_driver.sv | 156 +++++++++++++++
 tb/tb_lcd_hex_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_hex_pkg.sv
// Shared types, HD44780 command bytes and character helpers for the LCD hex driver.
// The ST_IDLE state exists only when LCD_CHANGE_ONLY_EN is defined.
package lcd_hex_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2
`ifdef LCD_CHANGE_ONLY_EN
    , ST_IDLE
`endif
  } lcd_state_t;

  typedef enum logic [2:0] {WC_IDLE, WC_SETUP, WC_PULSE, WC_HOLD, WC_WAIT} wc_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic       long_wait;
  } lcd_wr_t;

  function automatic logic [7:0] label_char(input logic [3:0] lbl, input logic [2:0] pos);
    logic [63:0] text;
    logic [5:0]  sh;
    case (lbl)
      4'd0:    text = "PC      ";
      4'd1:    text = "INSTR   ";
      4'd2:    text = "REG     ";
      4'd3:    text = "ALU     ";
      4'd4:    text = "STATUS  ";
      4'd5:    text = "DMEM    ";
      4'd6:    text = "CONTROL ";
      4'd7:    text = "ALUCTRL ";
      4'd8:    text = "EPC     ";
      default: text = {8{ASCII_SPACE}};
    endcase
    sh = {3'd7 - pos, 3'b000};
    return text[sh +: 8];
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Nibble 0 is the most significant one, as it is printed leftmost.
  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] k);
    logic [4:0] sh;
    sh = {3'd7 - k, 2'b00};
    return w[sh +: 4];
  endfunction

  function automatic lcd_wr_t wr_for(input lcd_state_t st, input logic [3:0] idx,
                                     input logic [31:0] d1, input logic [31:0] d2,
                                     input logic [3:0] lbl);
    lcd_wr_t w;
    w = '{data: CMD_LINE1, rs: 1'b0, long_wait: 1'b0};
    case (st)
      ST_INIT: begin
        case (idx[1:0])
          2'd0:    w.data = CMD_FUNC_SET;
          2'd1:    w.data = CMD_DISP_ON;
          2'd2:    begin w.data = CMD_CLEAR; w.long_wait = 1'b1; end
          default: w.data = CMD_ENTRY;
        endcase
      end
      ST_ADDR2: w.data = CMD_LINE2;
      ST_LINE1: begin
        w.rs   = 1'b1;
        w.data = idx[3] ? hex_ascii(nibble(d1, idx[2:0])) : label_char(lbl, idx[2:0]);
      end
      ST_LINE2: begin
        w.rs   = 1'b1;
        w.data = idx[3] ? hex_ascii(nibble(d2, idx[2:0])) : ASCII_SPACE;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_hex_driver_write_cycle.sv
// Bus timing engine: one SETUP / EN PULSE / HOLD / WAIT sequence per accepted byte.
module lcd_write_cycle
  import lcd_hex_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       start,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  input  logic       long_wait,
  output logic       done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_EN
);

  localparam int CNT_W = $clog2(EN_PULSE_CYC + CMD_WAIT_CYC + CLEAR_WAIT_CYC + 1);

  wc_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_last;
  logic             long_r;

  assign wait_last = long_r ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= WC_IDLE;
      cnt      <= '0;
      long_r   <= 1'b0;
      done     <= 1'b0;
      LCD_DATA <= '0;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        WC_IDLE: if (start) begin
          state    <= WC_SETUP;
          LCD_DATA <= wr_data;
          LCD_RS   <= wr_rs;
          long_r   <= long_wait;
        end
        WC_SETUP: begin
          state  <= WC_PULSE;
          LCD_EN <= 1'b1;
          cnt    <= '0;
        end
        WC_PULSE: begin
          if (cnt == CNT_W'(EN_PULSE_CYC - 1)) begin
            state  <= WC_HOLD;
            LCD_EN <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WC_HOLD: begin
          state <= WC_WAIT;
          cnt   <= '0;
        end
        WC_WAIT: begin
          if (cnt == wait_last) begin
            state <= WC_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= WC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_hex_driver.sv
// 16x2 HD44780 hex display driver: init sequence, then label + data1 / data2 frames.
// Define LCD_CHANGE_ONLY_EN to redraw only when the inputs change instead of continuously.
module lcd_hex_driver
  import lcd_hex_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int EN_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] i_data1,
  input  logic [31:0] i_data2,
  input  logic [3:0]  i_label,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int PW_W = $clog2(POWERUP_CYC + 1);

  lcd_state_t      state;
  logic [PW_W-1:0] pw_cnt;
  logic [3:0]      idx;
  logic [31:0]     f_d1, f_d2;
  logic [3:0]      f_lbl;
  lcd_wr_t         wr;
  logic            wr_start;
  logic            wr_done;

  assign LCD_RW = 1'b0;

  lcd_write_cycle #(
    .EN_PULSE_CYC  (EN_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_write (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .start    (wr_start),
    .wr_data  (wr.data),
    .wr_rs    (wr.rs),
    .long_wait(wr.long_wait),
    .done     (wr_done),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_EN   (LCD_EN)
  );

  // Each transition issues the next byte in the same edge, so the engine never idles extra.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= ST_PWRUP;
      pw_cnt       <= '0;
      idx          <= '0;
      // NOTE: snapshot registers are reset too, so the change compare never sees X.
      f_d1         <= '0;
      f_d2         <= '0;
      f_lbl        <= '0;
      wr           <= '0;
      wr_start     <= 1'b0;
      LCD_ON       <= 1'b0;
      o_busy       <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      LCD_ON       <= 1'b1;
      wr_start     <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        ST_PWRUP: begin
          if (pw_cnt == PW_W'(POWERUP_CYC - 1)) begin
            state    <= ST_INIT;
            idx      <= '0;
            wr       <= wr_for(ST_INIT, 4'd0, f_d1, f_d2, f_lbl);
            wr_start <= 1'b1;
          end else begin
            pw_cnt <= pw_cnt + PW_W'(1);
          end
        end
        ST_INIT: if (wr_done) begin
          if (idx == 4'd3) begin
            o_busy   <= 1'b0;
            state    <= ST_ADDR1;
            f_d1     <= i_data1;
            f_d2     <= i_data2;
            f_lbl    <= i_label;
            wr       <= wr_for(ST_ADDR1, 4'd0, i_data1, i_data2, i_label);
            wr_start <= 1'b1;
          end else begin
            idx      <= idx + 4'd1;
            wr       <= wr_for(ST_INIT, idx + 4'd1, f_d1, f_d2, f_lbl);
            wr_start <= 1'b1;
          end
        end
        ST_ADDR1: if (wr_done) begin
          state    <= ST_LINE1;
          idx      <= '0;
          wr       <= wr_for(ST_LINE1, 4'd0, f_d1, f_d2, f_lbl);
          wr_start <= 1'b1;
        end
        ST_LINE1: if (wr_done) begin
          if (idx == 4'd15) begin
            state <= ST_ADDR2;
            wr    <= wr_for(ST_ADDR2, 4'd0, f_d1, f_d2, f_lbl);
          end else begin
            idx <= idx + 4'd1;
            wr  <= wr_for(ST_LINE1, idx + 4'd1, f_d1, f_d2, f_lbl);
          end
          wr_start <= 1'b1;
        end
        ST_ADDR2: if (wr_done) begin
          state    <= ST_LINE2;
          idx      <= '0;
          wr       <= wr_for(ST_LINE2, 4'd0, f_d1, f_d2, f_lbl);
          wr_start <= 1'b1;
        end
        ST_LINE2: if (wr_done) begin
          if (idx == 4'd15) begin
            o_frame_done <= 1'b1;
`ifdef LCD_CHANGE_ONLY_EN
            state <= ST_IDLE;
`else
            state    <= ST_ADDR1;
            f_d1     <= i_data1;
            f_d2     <= i_data2;
            f_lbl    <= i_label;
            wr       <= wr_for(ST_ADDR1, 4'd0, i_data1, i_data2, i_label);
            wr_start <= 1'b1;
`endif
          end else begin
            idx      <= idx + 4'd1;
            wr       <= wr_for(ST_LINE2, idx + 4'd1, f_d1, f_d2, f_lbl);
            wr_start <= 1'b1;
          end
        end
`ifdef LCD_CHANGE_ONLY_EN
        ST_IDLE: if ({i_data1, i_data2, i_label} != {f_d1, f_d2, f_lbl}) begin
          state    <= ST_ADDR1;
          f_d1     <= i_data1;
          f_d2     <= i_data2;
          f_lbl    <= i_label;
          wr       <= wr_for(ST_ADDR1, 4'd0, i_data1, i_data2, i_label);
          wr_start <= 1'b1;
        end
`endif
        default: state <= ST_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Self-checking bench for lcd_hex_driver with shortened timing parameters.
module tb_lcd_hex_driver;

  localparam int PWR = 20;
  localparam int ENP = 2;
  localparam int CMW = 5;
  localparam int CLW = 10;
  // EN rise to next EN rise: pulse + hold + wait + done cycle + start cycle + setup.
  localparam int OVH = ENP + 1 + 1 + 1 + 1;

  logic        iCLK, iRST_N;
  logic [31:0] i_data1, i_data2;
  logic [3:0]  i_label;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, o_busy, o_frame_done;

  lcd_hex_driver #(
    .POWERUP_CYC(PWR), .EN_PULSE_CYC(ENP), .CMD_WAIT_CYC(CMW), .CLEAR_WAIT_CYC(CLW)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_data1(i_data1), .i_data2(i_data2), .i_label(i_label),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: logs every write and checks EN width and RS/DATA stability.
  int         cyc = 0;
  logic [8:0] wq[$];
  int         rq[$];
  logic       prev_en;
  logic       prev_rs;
  logic [7:0] prev_data;
  int         hi = 0;

  always @(negedge iCLK) begin
    cyc++;
    if (!iRST_N) begin
      hi = 0;
    end else if (LCD_EN && !prev_en) begin
      check("setup_stable", {LCD_RS, LCD_DATA}, {prev_rs, prev_data});
      wq.push_back({LCD_RS, LCD_DATA});
      rq.push_back(cyc);
      hi = 1;
    end else if (LCD_EN) begin
      hi++;
      check("pulse_stable", {LCD_RS, LCD_DATA}, {prev_rs, prev_data});
    end else if (prev_en) begin
      check("en_width", hi, ENP);
      check("hold_stable", {LCD_RS, LCD_DATA}, {prev_rs, prev_data});
    end
    prev_en   = iRST_N ? LCD_EN : 1'b0;
    prev_rs   = LCD_RS;
    prev_data = LCD_DATA;
  end

  task automatic step();
    @(negedge iCLK);
    #1;
  endtask

  task automatic wait_writes(input int n);
    int b = 0;
    while (wq.size() < n && b < 3000) begin
      step();
      b++;
    end
    check("writes_seen", 32'(wq.size() >= n), 1);
  endtask

  task automatic wait_frame();
    int b = 0;
    step();
    while (!o_frame_done && b < 1000) begin
      step();
      b++;
    end
    check("frame_done_seen", o_frame_done, 1);
  endtask

  task automatic clear_log();
    wq.delete();
    rq.delete();
  endtask

  task automatic check_frame(input int base, input logic [127:0] l1, input logic [127:0] l2);
    check("frame_len", wq.size(), base + 34);
    check("cmd_line1", wq[base], {1'b0, 8'h80});
    for (int i = 0; i < 16; i++)
      check($sformatf("line1_char%0d", i), wq[base + 1 + i], {1'b1, l1[8*(15-i) +: 8]});
    check("cmd_line2", wq[base + 17], {1'b0, 8'hC0});
    for (int i = 0; i < 16; i++)
      check($sformatf("line2_char%0d", i), wq[base + 18 + i], {1'b1, l2[8*(15-i) +: 8]});
  endtask

  // Releases reset and checks power-up delay, the init commands and their spacing.
  task automatic init_sequence();
    int on_cyc;
    clear_log();
    step();
    iRST_N = 1'b1;
    step();
    check("lcd_on_after_release", LCD_ON, 1);
    check("busy_during_init", o_busy, 1);
    on_cyc = cyc;
    wait_writes(4);
    check("first_en_rise", rq[0] - on_cyc, PWR + 1);
    check("init_cmd0", wq[0], {1'b0, 8'h38});
    check("init_cmd1", wq[1], {1'b0, 8'h0C});
    check("init_cmd2", wq[2], {1'b0, 8'h01});
    check("init_cmd3", wq[3], {1'b0, 8'h06});
    check("gap_after_38", rq[1] - rq[0], CMW + OVH);
    check("gap_after_0c", rq[2] - rq[1], CMW + OVH);
    check("gap_after_clear", rq[3] - rq[2], CLW + OVH);
    check("busy_before_last_init", o_busy, 1);
    wait_writes(5);
    check("busy_after_init", o_busy, 0);
    check("gap_after_06", rq[4] - rq[3], CMW + OVH);
  endtask

  typedef struct {
    logic [3:0]   lbl;
    logic [31:0]  d1;
    logic [31:0]  d2;
    logic [127:0] l1;
    logic [127:0] l2;
  } vec_t;

  vec_t         vecs[3];
  logic [127:0] l2_cur;
  int           en_hi, fd_hi, b;

  initial begin
    vecs[0] = '{4'd4,  32'h12345678, 32'h9ABCDEF0, "STATUS  12345678", "        9ABCDEF0"};
    vecs[1] = '{4'd12, 32'hCAFE0000, 32'h00000000, "        CAFE0000", "        00000000"};
    vecs[2] = '{4'd8,  32'h89ABCDEF, 32'h76543210, "EPC     89ABCDEF", "        76543210"};

    iRST_N  = 1'b0;
    i_label = 4'd0;
    i_data1 = 32'h0000001A;
    i_data2 = 32'hDEADBEEF;
    repeat (3) step();
    check("reset_outputs", {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, o_busy, o_frame_done},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    init_sequence();
    wait_frame();
    check_frame(4, "PC      0000001A", "        DEADBEEF");
    step();
    check("frame_done_one_cycle", o_frame_done, 0);
    clear_log();

`ifdef LCD_CHANGE_ONLY_EN
    en_hi = 0;
    fd_hi = 0;
    repeat (200) begin
      step();
      if (LCD_EN) en_hi++;
      if (o_frame_done) fd_hi++;
    end
    check("idle_no_en", en_hi, 0);
    check("idle_no_frame_done", fd_hi, 0);
    i_data2 = 32'h01234567;
    l2_cur  = "        01234567";
    step();
    step();
    check("restart_cmd", LCD_DATA, 8'h80);
`else
    l2_cur = "        DEADBEEF";
`endif

    // Mid-frame input change must only show up in the following frame.
    wait_writes(7);
    i_data1 = 32'hFFFFFFFF;
    wait_frame();
    check_frame(0, "PC      0000001A", l2_cur);
    clear_log();
    wait_frame();
    check_frame(0, "PC      FFFFFFFF", l2_cur);

    for (int v = 0; v < 3; v++) begin
`ifdef LCD_CHANGE_ONLY_EN
      clear_log();
      i_label = vecs[v].lbl;
      i_data1 = vecs[v].d1;
      i_data2 = vecs[v].d2;
      wait_frame();
`else
      i_label = vecs[v].lbl;
      i_data1 = vecs[v].d1;
      i_data2 = vecs[v].d2;
      wait_frame();
      clear_log();
      wait_frame();
`endif
      check_frame(0, vecs[v].l1, vecs[v].l2);
    end

    // Reset in the middle of an EN pulse aborts the write and replays init.
    step();
    b = 0;
    while (!LCD_EN && b < 1000) begin
      step();
      b++;
    end
    check("en_before_abort", LCD_EN, 1);
    iRST_N = 1'b0;
    #1;
    check("abort_outputs", {LCD_EN, LCD_ON, LCD_DATA, o_busy, o_frame_done},
          {1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    repeat (2) step();
    init_sequence();
    wait_frame();
    check_frame(4, vecs[2].l1, vecs[2].l2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
